// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam int PS2_DATA_BITS  = 8;
  localparam int DOUT_VALID_BIT = 8;
  localparam int DOUT_OVF_BIT   = 9;

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronizes the PS/2 pins, debounces the clock line and emits a one-cycle
// pulse on each falling edge of the filtered clock.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  input  logic ps2d,
  output logic ps2d_sync,
  output logic fall
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic             c_meta_reg, c_sync_reg;
  logic             d_meta_reg, d_sync_reg;
  logic             filt_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             fall_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      c_meta_reg <= 1'b1;
      c_sync_reg <= 1'b1;
      d_meta_reg <= 1'b1;
      d_sync_reg <= 1'b1;
      filt_reg   <= 1'b1;
      cnt_reg    <= '0;
      fall_reg   <= 1'b0;
    end else begin
      c_meta_reg <= ps2c;
      c_sync_reg <= c_meta_reg;
      d_meta_reg <= ps2d;
      d_sync_reg <= d_meta_reg;
      fall_reg   <= 1'b0;
      // Any sample back at the current level restarts the run count.
      if (c_sync_reg != filt_reg) begin
        if (cnt_reg == CNT_W'(FILTER_LEN - 1)) begin
          filt_reg <= c_sync_reg;
          cnt_reg  <= '0;
          fall_reg <= ~c_sync_reg;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign ps2d_sync = d_sync_reg;
  assign fall      = fall_reg;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: frame decoder, watchdog and scan-code FIFO exposed
// as a 16-bit status/data word with a pop-on-ack-edge interface.
import ps2_pkg::*;

module ps2_keyboard #(
  parameter int FIFO_DEPTH     = 4,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2c,
  input  logic        ps2d,
  input  logic        ack,
  output logic [15:0] dout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BIT_W = $clog2(PS2_DATA_BITS);

  logic ps2d_sync;
  logic fall;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2c     (ps2c),
    .ps2d     (ps2d),
    .ps2d_sync(ps2d_sync),
    .fall     (fall)
  );

  ps2_state_t                 state_reg;
  logic [BIT_W-1:0]           bit_cnt_reg;
  logic [PS2_DATA_BITS-1:0]   shift_reg;
  logic                       parity_reg;
  logic [WD_W-1:0]            wd_reg;
  logic                       push_reg;
  logic [PS2_DATA_BITS-1:0]   push_data_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      parity_reg    <= 1'b0;
      wd_reg        <= '0;
      push_reg      <= 1'b0;
      push_data_reg <= '0;
    end else begin
      push_reg <= 1'b0;

      if (fall || state_reg == IDLE)
        wd_reg <= '0;
      else if (wd_reg != WD_W'(TIMEOUT_CYCLES))
        wd_reg <= wd_reg + 1'b1;

      // A stalled partial frame is abandoned once the line has been quiet too long.
      if (state_reg != IDLE && wd_reg == WD_W'(TIMEOUT_CYCLES)) begin
        state_reg <= IDLE;
      end else if (fall) begin
        case (state_reg)
          IDLE: begin
            if (!ps2d_sync) begin
              state_reg   <= DATA;
              bit_cnt_reg <= '0;
            end
          end
          DATA: begin
            shift_reg   <= {ps2d_sync, shift_reg[PS2_DATA_BITS-1:1]};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == BIT_W'(PS2_DATA_BITS - 1))
              state_reg <= PARITY;
          end
          PARITY: begin
            parity_reg <= ps2d_sync;
            state_reg  <= STOP;
          end
          STOP: begin
            if (ps2d_sync && (^{shift_reg, parity_reg})) begin
              push_reg      <= 1'b1;
              push_data_reg <= shift_reg;
            end
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  logic [PS2_DATA_BITS-1:0] mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]         head_reg, tail_reg;
  logic [CNT_W-1:0]         count_reg;
  logic                     ovf_reg;
  logic                     ack_q_reg;
  logic                     empty, full, pop, push_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
  assign pop     = ack & ~ack_q_reg & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push_reg & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok)
      mem_reg[tail_reg] <= push_data_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      ack_q_reg <= 1'b0;
    end else begin
      ack_q_reg <= ack;
      if (push_ok)
        tail_reg <= tail_reg + 1'b1;
      if (pop)
        head_reg <= head_reg + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (pop)
        ovf_reg <= 1'b0;
      else if (push_reg && full)
        ovf_reg <= 1'b1;
    end
  end

  always_comb begin
    dout                 = 16'h0000;
    dout[DOUT_OVF_BIT]   = ovf_reg;
    dout[DOUT_VALID_BIT] = ~empty;
    if (!empty)
      dout[PS2_DATA_BITS-1:0] = mem_reg[head_reg];
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: stimulus queues expected dout values, a
// monitor compares each dout change against the queue.
module tb_ps2_keyboard;

  localparam int TIMEOUT = 2000;
  localparam int HALF    = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        ps2c;
  logic        ps2d;
  logic        ack;
  logic [15:0] dout;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic [15:0] prev_dout = 16'h0000;

  always #5 clk = ~clk;

  ps2_keyboard #(
    .FIFO_DEPTH    (4),
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .ps2c (ps2c),
    .ps2d (ps2d),
    .ack  (ack),
    .dout (dout)
  );

  // Monitor: every observed change of dout must match the next expected value.
  always @(negedge clk) begin
    if (mon_en && dout !== prev_dout) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change: got %h, none expected (prev %h)", dout, prev_dout);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          fails++;
          $display("FAIL dout_change: got %h, expected %h", dout, e);
        end else
          $display("[TB] dout -> %h ok", dout);
      end
    end
    prev_dout <= dout;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string name, input logic [15:0] e);
    tests++;
    if (dout !== e) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, dout, e);
    end else
      $display("[TB] %s dout=%h ok", name, dout);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2d = bits[i];
      cycles(HALF);
      ps2c = 1'b0;
      cycles(HALF);
      ps2c = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic par);
    logic [10:0] fr;
    fr = {1'b1, par, b, 1'b0};
    send_bits(fr, 11);
    ps2d = 1'b1;
    cycles(2 * HALF);
  endtask

  task automatic pulse_ack;
    ack = 1'b1;
    cycles(1);
    ack = 1'b0;
    cycles(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    ack   = 1'b0;
    cycles(5);
    check_now("reset_state", 16'h0000);
    reset = 1'b0;
    cycles(2);
    mon_en = 1'b1;

    // Single byte, then one pop.
    exp_q.push_back(16'h011C);
    send_byte(8'h1C, 1'b0);
    check_now("single_byte", 16'h011C);
    exp_q.push_back(16'h0000);
    pulse_ack();
    check_now("single_pop", 16'h0000);

    // Bad parity is dropped silently.
    send_byte(8'h1C, 1'b1);
    check_now("bad_parity", 16'h0000);

    // Overflow: five pushes into a four-entry FIFO.
    exp_q.push_back(16'h0101);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b0);
    exp_q.push_back(16'h0301);
    send_byte(8'h05, 1'b1);
    check_now("overflow", 16'h0301);
    exp_q.push_back(16'h0102);
    pulse_ack();
    check_now("ovf_pop1", 16'h0102);
    exp_q.push_back(16'h0103);
    pulse_ack();
    exp_q.push_back(16'h0104);
    pulse_ack();
    exp_q.push_back(16'h0000);
    pulse_ack();
    check_now("ovf_drained", 16'h0000);

    // Held ack pops exactly once.
    exp_q.push_back(16'h011C);
    send_byte(8'h1C, 1'b0);
    send_byte(8'hF0, 1'b1);
    exp_q.push_back(16'h01F0);
    ack = 1'b1;
    cycles(10);
    ack = 1'b0;
    cycles(5);
    check_now("held_ack", 16'h01F0);
    exp_q.push_back(16'h0000);
    pulse_ack();

    // Watchdog discards a stalled partial frame.
    send_bits(11'b000_0000_0000, 5);
    ps2d = 1'b1;
    cycles(TIMEOUT + 10);
    check_now("timeout_idle", 16'h0000);
    exp_q.push_back(16'h01F0);
    send_byte(8'hF0, 1'b1);
    check_now("after_timeout", 16'h01F0);
    exp_q.push_back(16'h0000);
    pulse_ack();

    // Reset in the middle of a frame with one byte queued.
    exp_q.push_back(16'h011C);
    send_byte(8'h1C, 1'b0);
    send_bits(11'b000_0001_1100 << 1, 5);
    exp_q.push_back(16'h0000);
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    ps2d  = 1'b1;
    cycles(5);
    check_now("reset_midframe", 16'h0000);
    exp_q.push_back(16'h0129);
    send_byte(8'h29, 1'b0);
    check_now("after_reset", 16'h0129);

    cycles(10);
    while (exp_q.size() != 0) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_change: got none, expected %h", e);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard.md
# ps2_keyboard

PS/2 keyboard receiver that presents received scan-code bytes to the CPU through a 16-bit memory-mapped data word and a read-acknowledge strobe. The system bus decoder drives `dout` onto the CPU data-in mux at both the keyboard status and keyboard data addresses. It raises `ack` only when the data address is read, which pops one byte. The block sits between the PS/2 connector pins and the top-level bus multiplexer.

## Interface
- `FIFO_DEPTH`, default 4: scan-code buffer entries (power of two).
- `FILTER_LEN`, default 8: consecutive equal samples required to accept a `ps2c` level change.
- `TIMEOUT_CYCLES`, default 100_000: idle cycles (2 ms at 50 MHz) after which a partial frame is discarded.
- `clk` in 1: system clock. All logic uses the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `ps2c` in 1: PS/2 clock pin, asynchronous.
- `ps2d` in 1: PS/2 data pin, asynchronous.
- `ack` in 1: read-acknowledge from the bus decoder. It is a level that may stay high for many cycles.
- `dout` out 16: status/data word.
  - bits 15:10 = 0
  - bit 9 = overflow
  - bit 8 = valid (FIFO not empty)
  - bits 7:0 = head byte, or 0 when the FIFO is empty

## Operation
- `ps2c` and `ps2d` each pass through a 2-flop synchronizer.
- The synchronized `ps2c` feeds the filter. The filtered level changes only after `FILTER_LEN` consecutive samples at the new level.
- A falling edge of filtered `ps2c` is a one-cycle `fall` pulse. Synchronized `ps2d` is sampled on `fall`.
- Frame format, 11 bits: start = 0, 8 data bits LSB first, odd parity, stop = 1.
- FSM states:
  - IDLE: on `fall` with data = 0, go to DATA with the bit count cleared. On `fall` with data = 1, stay in IDLE.
  - DATA: shift the sampled bit in on each `fall`. After the 8th bit, go to PARITY.
  - PARITY: latch the parity bit on `fall`, then go to STOP.
  - STOP: on `fall`, accept the frame only if stop = 1 and the parity of the 8 data bits plus the parity bit is odd. Return to IDLE in either case.
- A rejected frame (bad parity or bad stop bit) is dropped silently. No flag is set.
- Watchdog: a counter clears on every `fall`. If it reaches `TIMEOUT_CYCLES` in any state other than IDLE, the FSM returns to IDLE and the partial frame is discarded.
- FIFO push: on acceptance of a frame.
  - Push while full: the byte is dropped and overflow is set.
- FIFO pop: on the rising edge of `ack`, detected as `ack & ~ack_q`. This gives exactly one pop per acknowledge, however long `ack` stays high.
  - Pop while empty: no effect.
  - Pop clears overflow.
- Push and pop in the same cycle:
  - Not full: both happen and the count is unchanged.
  - Full: the pop frees a slot, the push succeeds, and overflow is not set.
- `dout` is driven combinationally from the FIFO head, count and overflow registers. Reading it has no side effect; only an `ack` edge pops.

## Timing
- Reset values:
  - `dout` = 16'h0000
  - FIFO empty; overflow = 0
  - FSM in IDLE; watchdog = 0
  - filter output = 1, synchronizers = 1, `ack_q` = 0
- Latency from `ps2c` pin edge to `fall`: 2 synchronizer cycles plus `FILTER_LEN` cycles.
- The push occurs the cycle after the stop-bit `fall`. `dout` shows the byte on the following cycle.
- Pop takes effect on the clock edge that samples the `ack` rising edge. `dout` shows the new head one cycle after `ack` rises.
- Reset asserted mid-frame discards the frame and empties the FIFO. The next complete frame after reset deasserts is received normally.

## Structure
- Package `ps2_pkg`:
  - state enum `ps2_state_t` {IDLE, DATA, PARITY, STOP}
  - constants `PS2_DATA_BITS` = 8
  - `DOUT_VALID_BIT` = 8, `DOUT_OVF_BIT` = 9
- Sub-module `ps2_clk_filter`: 2-flop synchronizer, debounce counter and falling-edge pulse. Parameterized by `FILTER_LEN`.
- The FIFO stays inline: a register array with head/tail pointers and a count.

## Test plan
- Single byte: send a frame with data 0x1C and parity 0 (three ones in the data) -> `dout` = 16'h011C. Pulse `ack` for 1 cycle -> `dout` = 16'h0000.
- Bad parity: send 0x1C with parity 1 -> `dout` stays 16'h0000.
- Overflow: send 0x01..0x05 with no `ack` -> `dout` = 16'h0301. Four `ack` pulses give 16'h0102, 16'h0103, 16'h0104, then 16'h0000. Byte 0x05 is lost.
- Held ack: two bytes 0x1C and 0xF0 queued; hold `ack` high for 10 cycles -> `dout` = 16'h01F0. Exactly one pop.
- Timeout: send start bit plus 4 data bits, idle for `TIMEOUT_CYCLES` + 10 cycles, then a full 0xF0 frame -> `dout` = 16'h01F0.
- Reset mid-frame: assert `reset` after 5 bits of a frame, with one byte already queued -> `dout` = 16'h0000. A following 0x29 frame -> `dout` = 16'h0129.
